keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/keypad_scanner_if.sv | 20 ++
 rtl/keypad_debounce.sv | 132 +++++++++++++
 rtl/keypad_scanner.sv | 114 +++++++++++
 tb/tb_keypad_scanner.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: debounce states,
// per-scan result kinds, column drive patterns and the key map.
package keypad_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESSED = 1'b1
  } db_state_e;

  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_kind_e;

  // Column index 0 drives the MSB low.
  localparam logic [0:3][3:0] COL_PAT = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // Indexed by {row, col}; row/col index 0 is the MSB line of each bus.
  localparam logic [0:15][3:0] KEY_MAP = {
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins and decoded key outputs grouped as one bundle.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  // Keypad / host side: drives rows, observes everything else.
  modport master (
    output row,
    input  col, key_code, key_valid, key_held
  );

  // Scanner side.
  modport slave (
    input  row,
    output col, key_code, key_valid, key_held
  );
endinterface

// File: rtl/keypad_debounce.sv
// Scan-level debounce: turns one result per full scan into accepted key
// events. A change is accepted only after DEBOUNCE_SCANS agreeing scans.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | no key accepted; counting identical SINGLE scans
//   ST_PRESSED | key_code accepted and held; counting NONE (release)
//              | or a different SINGLE (rollover)
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_done_i,
  input  scan_kind_e scan_kind_i,
  input  logic [3:0] scan_code_i,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_held_o
);

  localparam int              NW     = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [NW-1:0]   CNT_TC = NW'(DEBOUNCE_SCANS);

  db_state_e   state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  scan_kind_e  cand_kind_q, cand_kind_d;
  logic [3:0]  cand_code_q, cand_code_d;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        held_q, held_d;

  logic          same;
  logic [NW-1:0] cnt_step;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cand_kind_q <= SCAN_NONE;
      cand_code_q <= '0;
      code_q      <= '0;
      valid_q     <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_kind_q <= cand_kind_d;
      cand_code_q <= cand_code_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      held_q      <= held_d;
    end
  end

  // Next-state: a non-zero count always means the previous scan matched the candidate.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_kind_d = cand_kind_q;
    cand_code_d = cand_code_q;
    code_d      = code_q;
    valid_d     = 1'b0;
    held_d      = held_q;

    same = (cnt_q != '0) && (cand_kind_q == scan_kind_i) &&
           ((scan_kind_i == SCAN_NONE) || (cand_code_q == scan_code_i));
    if (!same)
      cnt_step = NW'(1);
    else if (cnt_q == CNT_TC)
      cnt_step = cnt_q;
    else
      cnt_step = cnt_q + 1'b1;

    if (scan_done_i) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_kind_i == SCAN_SINGLE) begin
            cnt_d       = cnt_step;
            cand_kind_d = SCAN_SINGLE;
            cand_code_d = scan_code_i;
            if (cnt_step == CNT_TC) begin
              code_d  = scan_code_i;
              valid_d = 1'b1;
              held_d  = 1'b1;
              state_d = ST_PRESSED;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          case (scan_kind_i)
            SCAN_NONE: begin
              cnt_d       = cnt_step;
              cand_kind_d = SCAN_NONE;
              if (cnt_step == CNT_TC) begin
                held_d  = 1'b0;
                state_d = ST_IDLE;
                cnt_d   = '0;
              end
            end
            SCAN_SINGLE: begin
              if (scan_code_i == code_q) begin
                cnt_d = '0;
              end else begin
                cnt_d       = cnt_step;
                cand_kind_d = SCAN_SINGLE;
                cand_code_d = scan_code_i;
                if (cnt_step == CNT_TC) begin
                  code_d  = scan_code_i;
                  valid_d = 1'b1;
                  cnt_d   = '0;
                end
              end
            end
            default: cnt_d = '0;
          endcase
        end
      endcase
    end
  end

  assign key_code_o  = code_q;
  assign key_valid_o = valid_q;
  assign key_held_o  = held_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row synchronizer, column sequencer and per-scan row
// decode feeding the scan-level debounce.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES    = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       RST_BTN,
  keypad_scanner_if.slave kif
);

  localparam int            CW       = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LOAD = CW'(SCAN_CYCLES - 1);

  logic [3:0]    row_meta_q, row_sync_q;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [1:0]    col_q, col_d;
  scan_kind_e    acc_kind_q, acc_kind_d;
  logic [3:0]    acc_code_q, acc_code_d;

  logic          col_end;
  logic          scan_done;
  scan_kind_e    col_kind, base_kind, res_kind;
  logic [3:0]    col_code, res_code;

  // Two-flop row synchronizer; resets to all-released.
  always_ff @(posedge clk or negedge RST_BTN) begin
    if (!RST_BTN) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= kif.row;
      row_sync_q <= row_meta_q;
    end
  end

  // Column dwell down-counter, column index and partial-scan accumulator.
  always_ff @(posedge clk or negedge RST_BTN) begin
    if (!RST_BTN) begin
      cyc_q      <= CYC_LOAD;
      col_q      <= '0;
      acc_kind_q <= SCAN_NONE;
      acc_code_q <= '0;
    end else begin
      cyc_q      <= cyc_d;
      col_q      <= col_d;
      acc_kind_q <= acc_kind_d;
      acc_code_q <= acc_code_d;
    end
  end

  // Decode the current column's rows and fold them into this scan's result.
  always_comb begin
    col_kind = SCAN_NONE;
    col_code = '0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync_q[3-r]) begin
        if (col_kind == SCAN_NONE) begin
          col_kind = SCAN_SINGLE;
          col_code = KEY_MAP[{2'(r), col_q}];
        end else begin
          col_kind = SCAN_MULTI;
        end
      end
    end

    // Column 0 starts a fresh scan, so stale accumulator content is ignored.
    base_kind = (col_q == 2'd0) ? SCAN_NONE : acc_kind_q;
    if (base_kind == SCAN_NONE) begin
      res_kind = col_kind;
      res_code = col_code;
    end else if (col_kind == SCAN_NONE) begin
      res_kind = base_kind;
      res_code = acc_code_q;
    end else begin
      res_kind = SCAN_MULTI;
      res_code = acc_code_q;
    end
  end

  // Sequencer: rows are sampled on the terminal-count clock of each column.
  always_comb begin
    cyc_d      = cyc_q - 1'b1;
    col_d      = col_q;
    acc_kind_d = acc_kind_q;
    acc_code_d = acc_code_q;
    col_end    = (cyc_q == '0);
    scan_done  = col_end && (col_q == 2'd3);
    if (col_end) begin
      cyc_d      = CYC_LOAD;
      col_d      = col_q + 1'b1;
      acc_kind_d = res_kind;
      acc_code_d = res_code;
    end
  end

  assign kif.col = COL_PAT[col_q];

  keypad_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clk         (clk),
    .rst_n       (RST_BTN),
    .scan_done_i (scan_done),
    .scan_kind_i (res_kind),
    .scan_code_i (res_code),
    .key_code_o  (kif.key_code),
    .key_valid_o (kif.key_valid),
    .key_held_o  (kif.key_held)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_CYCLES=4, DEBOUNCE_SCANS=3.
module tb_keypad_scanner;

  localparam int SC   = 4;
  localparam int DS   = 3;
  localparam int SCAN = 4 * SC;

  // Key mask bit = row*4 + col, row/col 0 on the MSB line.
  localparam int K1 = 0;
  localparam int KA = 3;
  localparam int K5 = 5;
  localparam int KB = 7;
  localparam int K9 = 10;
  localparam int KD = 15;

  logic        clk = 1'b0;
  logic        RST_BTN = 1'b0;
  logic [15:0] pressed = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int last_valid_cyc = -1;
  logic prev_valid = 1'b0;
  int v0;

  keypad_scanner_if kif();

  function automatic logic [3:0] row_model(logic [3:0] c, logic [15:0] p);
    logic [3:0] r;
    r = 4'hF;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (p[ri*4+ci] && !c[3-ci]) r[3-ri] = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] exp_col(int c);
    case ((c / SC) % 4)
      0:       return 4'b0111;
      1:       return 4'b1011;
      2:       return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  assign kif.row = row_model(kif.col, pressed);

  keypad_scanner #(
    .SCAN_CYCLES    (SC),
    .DEBOUNCE_SCANS (DS)
  ) dut (
    .clk     (clk),
    .RST_BTN (RST_BTN),
    .kif     (kif)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge RST_BTN)
    if (!RST_BTN) cyc <= 0;
    else          cyc <= cyc + 1;

  always @(negedge clk) begin
    checks++;
    assert (kif.col === exp_col(cyc)) else begin
      errors++;
      $error("FAIL col_seq cyc=%0d observed=%b expected=%b", cyc, kif.col, exp_col(cyc));
    end
    checks++;
    assert ((kif.key_valid & prev_valid) === 1'b0) else begin
      errors++;
      $error("FAIL valid_back_to_back cyc=%0d observed=1 expected=0", cyc);
    end
    if (kif.key_valid === 1'b1) begin
      valid_cnt++;
      last_valid_cyc = cyc;
    end
    prev_valid = kif.key_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scans(input int n);
    repeat (SCAN * n) @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_col", 32'(kif.col), 32'h7);
    check("rst_code", 32'(kif.key_code), 32'h0);
    check("rst_valid", 32'(kif.key_valid), 32'h0);
    check("rst_held", 32'(kif.key_held), 32'h0);
    @(negedge clk);
    RST_BTN = 1'b1;

    // No keys for 10 scans
    scans(10);
    check("idle_valid_cnt", 32'(valid_cnt), 32'd0);
    check("idle_held", 32'(kif.key_held), 32'h0);

    // Clean "5"
    v0 = valid_cnt;
    pressed = 16'(1) << K5;
    scans(2);
    check("k5_early", 32'(valid_cnt - v0), 32'd0);
    scans(1);
    check("k5_pulse", 32'(valid_cnt - v0), 32'd1);
    check("k5_pulse_cyc", 32'(last_valid_cyc), 32'(10 * SCAN + 3 * SCAN));
    check("k5_code", 32'(kif.key_code), 32'h5);
    check("k5_held", 32'(kif.key_held), 32'h1);
    scans(2);
    check("k5_single_pulse", 32'(valid_cnt - v0), 32'd1);
    check("k5_still_held", 32'(kif.key_held), 32'h1);

    // Release "5"
    pressed = '0;
    scans(2);
    check("k5_rel_2", 32'(kif.key_held), 32'h1);
    scans(1);
    check("k5_rel_3", 32'(kif.key_held), 32'h0);
    check("k5_rel_code", 32'(kif.key_code), 32'h5);

    // Bouncing "9" then stable
    v0 = valid_cnt;
    for (int i = 0; i < 6; i++) begin
      pressed = (i % 2 == 0) ? (16'(1) << K9) : 16'h0;
      scans(1);
    end
    check("k9_bounce", 32'(valid_cnt - v0), 32'd0);
    pressed = 16'(1) << K9;
    scans(2);
    check("k9_stable_2", 32'(valid_cnt - v0), 32'd0);
    scans(1);
    check("k9_pulse", 32'(valid_cnt - v0), 32'd1);
    check("k9_pulse_cyc", 32'(last_valid_cyc), 32'(cyc));
    check("k9_code", 32'(kif.key_code), 32'h9);
    check("k9_held", 32'(kif.key_held), 32'h1);
    pressed = '0;
    scans(3);
    check("k9_released", 32'(kif.key_held), 32'h0);

    // "A", then "A"+"B", then release
    v0 = valid_cnt;
    pressed = 16'(1) << KA;
    scans(3);
    check("kA_pulse", 32'(valid_cnt - v0), 32'd1);
    check("kA_code", 32'(kif.key_code), 32'hA);
    pressed = (16'(1) << KA) | (16'(1) << KB);
    scans(4);
    check("kAB_no_pulse", 32'(valid_cnt - v0), 32'd1);
    check("kAB_code", 32'(kif.key_code), 32'hA);
    check("kAB_held", 32'(kif.key_held), 32'h1);
    pressed = '0;
    scans(2);
    check("kA_rel_2", 32'(kif.key_held), 32'h1);
    scans(1);
    check("kA_rel_3", 32'(kif.key_held), 32'h0);
    check("kA_rel_code", 32'(kif.key_code), 32'hA);
    check("kA_rel_no_pulse", 32'(valid_cnt - v0), 32'd1);

    // "1" then roll over to "D"
    v0 = valid_cnt;
    pressed = 16'(1) << K1;
    scans(3);
    check("k1_pulse", 32'(valid_cnt - v0), 32'd1);
    check("k1_code", 32'(kif.key_code), 32'h1);
    pressed = 16'(1) << KD;
    scans(2);
    check("kD_early", 32'(valid_cnt - v0), 32'd1);
    check("kD_early_code", 32'(kif.key_code), 32'h1);
    scans(1);
    check("kD_pulse", 32'(valid_cnt - v0), 32'd2);
    check("kD_code", 32'(kif.key_code), 32'hD);
    check("kD_held", 32'(kif.key_held), 32'h1);

    // Asynchronous reset mid-column while "D" is held
    scans(1);
    repeat (6) @(negedge clk);
    #2;
    RST_BTN = 1'b0;
    #1;
    check("arst_code", 32'(kif.key_code), 32'h0);
    check("arst_valid", 32'(kif.key_valid), 32'h0);
    check("arst_held", 32'(kif.key_held), 32'h0);
    check("arst_col", 32'(kif.col), 32'h7);
    repeat (2) @(negedge clk);
    RST_BTN = 1'b1;
    v0 = valid_cnt;
    scans(2);
    check("rearm_early", 32'(valid_cnt - v0), 32'd0);
    check("rearm_held_early", 32'(kif.key_held), 32'h0);
    scans(1);
    check("rearm_pulse", 32'(valid_cnt - v0), 32'd1);
    check("rearm_pulse_cyc", 32'(last_valid_cyc), 32'(3 * SCAN));
    check("rearm_code", 32'(kif.key_code), 32'hD);
    check("rearm_held", 32'(kif.key_held), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
